// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_display
// Brief    : Time-multiplexed driver for an N-digit common-anode seven-segment
//            display. It decodes BCD to active-low segments, drives one digit
//            at a time, supports per-digit decimal points, and takes value
//            updates only at frame boundaries so a frame never tears.
//            Optional macro BCD_SCAN_LEADING_ZERO_BLANK_EN enables blanking
//            of leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_scan_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    enable,
    output logic [6:0]              out,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    dp
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_sh_val;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic                    r_first;
    logic [6:0]              r_out;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic                    r_dp;

    logic                    w_term;
    logic                    w_idx_last;
    logic                    w_frame_wrap;
    logic [3:0]              w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [3:0]              w_cur_nib;
    logic                    w_cur_blank;
    logic [6:0]              w_cur_seg;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign w_term       = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_idx_last   = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_frame_wrap = enable && w_term && w_idx_last;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_nib[gi] = r_sh_val[4*gi +: 4];
            assign w_sel[gi] = (r_idx == IDX_W'(gi));
        end
    endgenerate

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    // Walk from the most significant digit down; a digit is blank while every
    // shadow nibble above it is zero. Digit 0 and dp-lit digits always show.
    logic w_hi_zero;
    always_comb begin
        w_hi_zero = 1'b1;
        w_blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_blank[i] = (i != 0) && w_hi_zero && (w_nib[i] == 4'd0) && !r_sh_dp[i];
            w_hi_zero  = w_hi_zero && (w_nib[i] == 4'd0);
        end
    end
`else
    assign w_blank = '0;
`endif

    assign w_cur_nib   = w_nib[r_idx];
    assign w_cur_blank = w_blank[r_idx];
    assign w_cur_seg   = w_cur_blank ? c_SEG_BLANK : f_decode(w_cur_nib);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_sh_val <= '0;
            r_sh_dp  <= '0;
            r_first  <= 1'b1;
            r_out    <= c_SEG_BLANK;
            r_anode  <= '1;
            r_dp     <= 1'b1;
        end else begin
            r_first <= 1'b0;
            // Shadow loads only at frame boundaries so every digit of a frame
            // comes from one sample.
            if (r_first || w_frame_wrap) begin
                r_sh_val <= value;
                r_sh_dp  <= dp_in;
            end
            if (enable) begin
                if (w_term) begin
                    r_cnt <= '0;
                    r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_anode <= ~w_sel;
                r_out   <= w_cur_seg;
                r_dp    <= ~r_sh_dp[r_idx];
            end else begin
                r_anode <= '1;
                r_out   <= c_SEG_BLANK;
                r_dp    <= 1'b1;
            end
        end
    end

    assign out   = r_out;
    assign anode = r_anode;
    assign dp    = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_scan_display
// Brief    : Scoreboard bench for bcd_scan_display (4 digits, dwell 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_display;

    localparam int c_ND  = 4;
    localparam int c_DIV = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SB = 7'b1111111;

    logic              clk;
    logic              reset;
    logic [4*c_ND-1:0] value;
    logic [c_ND-1:0]   dp_in;
    logic              enable;
    logic [6:0]        out;
    logic [c_ND-1:0]   anode;
    logic              dp;

    typedef struct {
        logic [3:0] an;
        logic [6:0] sg;
        logic       d;
        bit         cs;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    bcd_scan_display #(
        .NUM_DIGITS  (c_ND),
        .REFRESH_DIV (c_DIV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .value  (value),
        .dp_in  (dp_in),
        .enable (enable),
        .out    (out),
        .anode  (anode),
        .dp     (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are presented every cycle; compare one queued entry per cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (anode !== e.an) begin
                n_fail++;
                $display("FAIL anode @%0t: got %b expected %b", $time, anode, e.an);
            end
            if (e.cs) begin
                n_checks++;
                if (out !== e.sg) begin
                    n_fail++;
                    $display("FAIL out @%0t: got %b expected %b", $time, out, e.sg);
                end
            end
            n_checks++;
            if (dp !== e.d) begin
                n_fail++;
                $display("FAIL dp @%0t: got %b expected %b", $time, dp, e.d);
            end
        end
    end

    task automatic cyc(input logic [3:0] an, input logic [6:0] sg, input logic d, input bit cs);
        @(posedge clk);
        exp_q.push_back('{an: an, sg: sg, d: d, cs: cs});
        #1;
    endtask

    task automatic digit(input int di, input logic [6:0] sg, input logic [3:0] dpm, input int n);
        logic [3:0] a;
        a = 4'b0001 << di;
        for (int k = 0; k < n; k++) cyc(~a, sg, ~dpm[di], 1'b1);
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3, input logic [3:0] dpm);
        digit(0, s0, dpm, c_DIV);
        digit(1, s1, dpm, c_DIV);
        digit(2, s2, dpm, c_DIV);
        digit(3, s3, dpm, c_DIV);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        enable   = 1'b0;
        value    = 16'h1234;
        dp_in    = 4'b0000;
        #1;
        cyc(4'b1111, SB, 1'b1, 1'b1);
        cyc(4'b1111, SB, 1'b1, 1'b1);
        reset = 1'b0;
        cyc(4'b1111, SB, 1'b1, 1'b1);

        // Basic scan of 1234
        enable = 1'b1;
        frame(S4, S3, S2, S1, 4'b0000);

        // Mid-frame update is deferred to the next frame
        digit(0, S4, 4'b0000, 4);
        digit(1, S3, 4'b0000, 4);
        value = 16'h5678;
        digit(2, S2, 4'b0000, 4);
        digit(3, S1, 4'b0000, 4);
        value = 16'hABCF;
        dp_in = 4'b0100;
        frame(S8, S7, S6, S5, 4'b0000);

        // Invalid nibbles blank, scan and dp continue
        value = 16'h1234;
        dp_in = 4'b0000;
        frame(SB, SB, SB, SB, 4'b0100);

        // Enable dropped mid-digit 1, resumes with remaining dwell
        digit(0, S4, 4'b0000, 4);
        digit(1, S3, 4'b0000, 2);
        enable = 1'b0;
        cyc(4'b1111, SB, 1'b1, 1'b1);
        cyc(4'b1111, SB, 1'b1, 1'b1);
        cyc(4'b1111, SB, 1'b1, 1'b1);
        enable = 1'b1;
        digit(1, S3, 4'b0000, 2);
        digit(2, S2, 4'b0000, 4);
        digit(3, S1, 4'b0000, 4);

        // Reset during digit 3 with enable high
        digit(0, S4, 4'b0000, 4);
        digit(1, S3, 4'b0000, 4);
        digit(2, S2, 4'b0000, 4);
        digit(3, S1, 4'b0000, 2);
        reset = 1'b1;
        cyc(4'b1111, SB, 1'b1, 1'b1);
        reset = 1'b0;
        cyc(4'b1110, S0, 1'b1, 1'b0);
        digit(0, S4, 4'b0000, 3);
        digit(1, S3, 4'b0000, 4);
        digit(2, S2, 4'b0000, 4);
        digit(3, S1, 4'b0000, 4);

        // Leading-zero handling
        value = 16'h0040;
        frame(S4, S3, S2, S1, 4'b0000);
        value = 16'h0000;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
        frame(S0, S4, SB, SB, 4'b0000);
        dp_in = 4'b1000;
        frame(S0, SB, SB, SB, 4'b0000);
        frame(S0, SB, SB, S0, 4'b1000);
`else
        frame(S0, S4, S0, S0, 4'b0000);
        dp_in = 4'b1000;
        frame(S0, S0, S0, S0, 4'b0000);
        frame(S0, S0, S0, S0, 4'b1000);
`endif

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display, generalising the single-digit static BCD display to NUM_DIGITS digits.
- Scans one digit at a time at a programmable refresh rate and decodes each BCD nibble to active-low segments.
- Provides per-digit decimal points and tear-free value updates.
- Sits between lab datapaths (counters, switch inputs) and the board's seven-segment pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000, clock cycles each digit stays lit; minimum 2.
- CNT_W, $clog2(REFRESH_DIV), width of the refresh counter; derived, do not override.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- value  input  4*NUM_DIGITS  BCD nibbles; value[3:0] is digit 0, the rightmost digit.
- dp_in  input  NUM_DIGITS  decimal point request per digit; 1 means lit.
- enable  input  1  1 = scan the display; 0 = all digits dark.
- out  output  7  segments {g,f,e,d,c,b,a}, active-low.
- anode  output  NUM_DIGITS  digit selects, active-low; bit i drives digit i.
- dp  output  1  decimal point, active-low.

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - out = 7'b1111111, anode = all ones, dp = 1.
  - refresh counter = 0, digit index = 0.
  - shadow value and shadow dp = 0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 while enable = 1.
  - On the terminal count it returns to 0 and the digit index advances modulo NUM_DIGITS: NUM_DIGITS-1 wraps to 0.
- Shadow registers:
  - value and dp_in are captured into shadow registers only when the index wraps to 0, and on the first cycle after reset.
  - All digits within one scan frame therefore come from the same sample, so there is no tearing.
- Outputs are registered, with one cycle of latency from index/shadow to pins.
- anode has exactly one zero bit (at the current index) while enabled; it is never one-hot-with-glitch.
- out and anode update on the same edge.
- Decode table, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles 10–15 are invalid: out = 1111111 (blank). The anode is still asserted so timing stays uniform.
- dp = ~shadow_dp[index].
- enable = 0:
  - Counter and index hold.
  - The next edge drives anode = all ones, out = 1111111, dp = 1.
  - Re-enabling resumes from the held index and count.
- Reset mid-scan: the next edge restores all reset values regardless of enable. Scanning starts at digit 0 with count 0.
- NUM_DIGITS = 1: the index stays 0. The shadow registers reload every REFRESH_DIV cycles.

Optional Feature:
- Macro: BCD_SCAN_LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit whose shadow nibble is 0 and whose higher-order digits are all 0 is blanked (out = 1111111).
  - Digit 0 is never blanked, so a value of zero shows a single "0".
  - A digit whose dp bit is set is never blanked.
  - The blank mask is computed from the shadow registers, not the live inputs.
- Undefined: every digit displays its decoded nibble, including leading zeros.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4 unless noted):
- Reset, then enable=1, value=16'h1234, dp_in=0:
  - Anode sequence is 1110, 1101, 1011, 0111, each held 4 cycles.
  - out is 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1) in step with the anode; dp = 1 throughout.
- Change value from 16'h1234 to 16'h5678 while index = 2:
  - Digits 2 and 3 still show 2 and 1 for the rest of the frame.
  - The next frame shows 8, 7, 6, 5.
- value=16'hABCF, dp_in=4'b0100:
  - out = 1111111 on all digits while the anode scan continues.
  - dp = 0 only while anode = 1011.
- enable dropped mid-digit 1:
  - Next cycle: anode = 1111, out = 1111111.
  - After re-enabling, digit 1 finishes its remaining count before digit 2.
- Assert reset during digit 3, enable held high:
  - Next edge: all outputs at reset values.
  - Scan restarts at anode = 1110 with a full 4-cycle dwell.
- With BCD_SCAN_LEADING_ZERO_BLANK_EN defined, value=16'h0040, dp_in=0:
  - Digits 3 and 2 are blank; digit 1 shows 4; digit 0 shows 0.
  - value=16'h0000 shows only digit 0 as 0.
